// File: rtl/data_sync_pkg.sv
// Shared definitions for the bus synchronizer pair: the launcher FSM
// encoding and default widths and depths.
package data_sync_pkg;

    localparam int unsigned DEF_BUS_WIDTH  = 8;
    localparam int unsigned DEF_NUM_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD     = 2'b01,
        ST_WAIT_ACK = 2'b10
    } launch_state_e;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer.
//   CLK      destination clock
//   RST      synchronous active-low reset, clears every stage
//   async_in asynchronous input bit
//   sync_out output of the last stage
module bit_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] sync_q;

    // Shift chain; stage 0 is the metastability-exposed flop.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_launcher.sv
// Source-side launcher of a toggle-handshake bus crossing. Captures a word,
// holds it on tx_bus, toggles tx_req and waits for the synchronized rx_ack
// toggle to match.
//   CLK, RST     source clock, synchronous active-low reset
//   src_data     word to launch, sampled only on the accept edge
//   src_valid    src_data is valid
//   src_ready    high while IDLE (combinational from state)
//   tx_bus       launched word, held until the next accept
//   tx_req       request toggle, one toggle per word
//   rx_ack       asynchronous acknowledge toggle from the receiver
//   done         one-cycle pulse when a word is acknowledged
//   err_timeout  sticky, an ack took TIMEOUT or more wait cycles
//   err_proto    sticky, synchronized ack moved outside WAIT_ACK
module data_sync_launcher
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [BUS_WIDTH-1:0] tx_bus,
    output logic                 tx_req,
    input  logic                 rx_ack,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 err_proto
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    launch_state_e    state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             ack_s;
    logic             ack_q;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (rx_ack),
        .sync_out (ack_s)
    );

    assign src_ready    = (state == ST_IDLE);
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);

    // Launch FSM with data/toggle registers, timeout counter and error flags.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= ST_IDLE;
            tx_bus      <= '0;
            tx_req      <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            wait_cnt    <= '0;
            ack_q       <= 1'b0;
        end else begin
            done  <= 1'b0;
            ack_q <= ack_s;

            // A legitimate ack only ever moves while a request is outstanding.
            if ((state != ST_WAIT_ACK) && (ack_s != ack_q)) begin
                err_proto <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (src_valid) begin
                        tx_bus <= src_data;
                        state  <= ST_LOAD;
                    end
                end
                // Data has been stable for a cycle; now announce it.
                ST_LOAD: begin
                    tx_req   <= ~tx_req;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_s == tx_req) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == CNT_MAX) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_launcher.sv
module tb_data_sync_launcher;

    localparam int unsigned BW = 8;
    localparam int unsigned NS = 2;
    localparam int unsigned TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [BW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [BW-1:0] tx_bus;
    logic          tx_req;
    logic          rx_ack = 1'b0;
    logic          done;
    logic          err_timeout;
    logic          err_proto;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: request phase and sticky flags.
    logic exp_req   = 1'b0;
    logic exp_to    = 1'b0;
    logic exp_proto = 1'b0;

    data_sync_launcher #(
        .BUS_WIDTH  (BW),
        .NUM_STAGES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .tx_bus      (tx_bus),
        .tx_req      (tx_req),
        .rx_ack      (rx_ack),
        .done        (done),
        .err_timeout (err_timeout),
        .err_proto   (err_proto)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0; src_valid = 1'b0; rx_ack = 1'b0;
        exp_req = 1'b0; exp_to = 1'b0; exp_proto = 1'b0;
        @(negedge CLK);
        total++; if (tx_bus !== '0) begin bad++; $display("FAIL rst_bus got=%h exp=00", tx_bus); end
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", tx_req); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_errto got=%b exp=0", err_timeout); end
        total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL rst_errproto got=%b exp=0", err_proto); end
        RST = 1'b1;
        @(negedge CLK);
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", src_ready); end
    endtask

    // One complete word; the receiver acks d cycles after the request toggle.
    // Called at a negedge where the launcher should be idle.
    task automatic do_word(input logic [BW-1:0] w, input int d, input bit hold);
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL ready_idle got=%b exp=1", src_ready); end
        src_data = w; src_valid = 1'b1;
        @(negedge CLK);
        total++; if (tx_bus !== w) begin bad++; $display("FAIL bus_accept got=%h exp=%h", tx_bus, w); end
        total++; if (tx_req !== exp_req) begin bad++; $display("FAIL req_pre got=%b exp=%b", tx_req, exp_req); end
        total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL ready_load got=%b exp=0", src_ready); end
        src_valid = hold; src_data = BW'($urandom);
        @(negedge CLK);
        exp_req = ~exp_req;
        total++; if (tx_req !== exp_req) begin bad++; $display("FAIL req_toggle got=%b exp=%b", tx_req, exp_req); end
        total++; if (tx_bus !== w) begin bad++; $display("FAIL bus_toggle got=%h exp=%h", tx_bus, w); end
        if (d == 0) rx_ack = exp_req;
        for (int j = 1; j <= d + int'(NS); j++) begin
            src_data = BW'($urandom);
            @(negedge CLK);
            if (j >= int'(TO)) exp_to = 1'b1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early j=%0d got=%b exp=0", j, done); end
            total++; if (tx_bus !== w) begin bad++; $display("FAIL bus_hold j=%0d got=%h exp=%h", j, tx_bus, w); end
            total++; if (err_timeout !== exp_to) begin bad++; $display("FAIL errto_wait j=%0d got=%b exp=%b", j, err_timeout, exp_to); end
            total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL ready_wait j=%0d got=%b exp=0", j, src_ready); end
            if (j == d) rx_ack = exp_req;
        end
        @(negedge CLK);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%b exp=1", done); end
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL ready_done got=%b exp=1", src_ready); end
        total++; if (tx_bus !== w) begin bad++; $display("FAIL bus_done got=%h exp=%h", tx_bus, w); end
        total++; if (err_timeout !== exp_to) begin bad++; $display("FAIL errto_done got=%b exp=%b", err_timeout, exp_to); end
        total++; if (err_proto !== exp_proto) begin bad++; $display("FAIL proto_done got=%b exp=%b", err_proto, exp_proto); end
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", tag, src_ready); end
            total++; if (tx_req !== exp_req) begin bad++; $display("FAIL %s_req got=%b exp=%b", tag, tx_req, exp_req); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done got=%b exp=0", tag, done); end
        end
    endtask

    task automatic test_single_word();
        do_word(8'hA5, 2, 1'b0);
        check_idle(2, "single");
    endtask

    task automatic test_back_to_back();
        test_reset();
        do_word(8'h01, 0, 1'b1);
        do_word(8'h02, 0, 1'b1);
        do_word(8'h03, 0, 1'b1);
        src_valid = 1'b0;
        check_idle(4, "b2b");
    endtask

    task automatic test_random();
        test_reset();
        for (int n = 0; n < 12; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            do_word(BW'($urandom), int'($urandom_range(0, 3)), hold);
            if (!hold) begin
                src_valid = 1'($urandom_range(0, 1));
                src_valid = 1'b0;
                check_idle(int'($urandom_range(0, 2)), "rand");
            end
        end
        src_valid = 1'b0;
        check_idle(2, "rand_end");
    endtask

    task automatic test_timeout();
        test_reset();
        do_word(8'h3C, 6, 1'b0);
        check_idle(3, "to");
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL errto_sticky got=%b exp=1", err_timeout); end
    endtask

    task automatic test_proto_reset();
        test_reset();
        rx_ack = 1'b1;
        for (int j = 1; j <= int'(NS); j++) begin
            @(negedge CLK);
            total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL proto_early j=%0d got=%b exp=0", j, err_proto); end
        end
        @(negedge CLK);
        total++; if (err_proto !== 1'b1) begin bad++; $display("FAIL proto_set got=%b exp=1", err_proto); end
        rx_ack = 1'b0;
        repeat (NS + 2) @(negedge CLK);
        total++; if (err_proto !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b exp=1", err_proto); end
        src_data = 8'h7E; src_valid = 1'b1;
        @(negedge CLK);
        src_valid = 1'b0;
        @(negedge CLK);
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL proto_req got=%b exp=1", tx_req); end
        RST = 1'b0;
        @(negedge CLK);
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", tx_req); end
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", src_ready); end
        total++; if (err_proto !== 1'b0) begin bad++; $display("FAIL midrst_proto got=%b exp=0", err_proto); end
        total++; if (tx_bus !== '0) begin bad++; $display("FAIL midrst_bus got=%h exp=00", tx_bus); end
        RST = 1'b1;
        exp_req = 1'b0; exp_to = 1'b0; exp_proto = 1'b0;
        check_idle(3, "midrst");
        do_word(8'hC3, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random();
        test_timeout();
        test_proto_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
